// File: rtl/palette_pkg.sv
// -----------------------------------------------------------------------------
// palette_pkg
// Shared definitions for the palette lookup block:
//   - FSM state type for the default-table fill
//   - L8 / L4 colour level tables used to build the default palette
//   - align_level(): places an 8-bit level MSB-aligned in a channel of ch_w bits
//   - default_entry(): default {R,G,B} word for a palette index
//   - color_t: colour word at the default channel width
// -----------------------------------------------------------------------------
package palette_pkg;

    localparam int MAX_CH_W = 32;
    localparam int DEF_CH_W = 8;

    typedef logic [3*DEF_CH_W-1:0] color_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lut_state_t;

    // Entry k lives at bits [8k +: 8]
    localparam logic [63:0] L8_TABLE = {8'hFF, 8'hE0, 8'hB0, 8'h90,
                                        8'h70, 8'h50, 8'h20, 8'h00};
    localparam logic [31:0] L4_TABLE = {8'hFF, 8'hB0, 8'h50, 8'h00};

    function automatic logic [7:0] level8(input logic [2:0] k);
        return L8_TABLE[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] level4(input logic [1:0] k);
        return L4_TABLE[{k, 3'b000} +: 8];
    endfunction

    // The level is first placed at the top of a MAX_CH_W field and then shifted
    // down so its MSB lands on bit ch_w-1: narrower channels truncate the low
    // bits, wider channels get zero fill below.
    function automatic logic [MAX_CH_W-1:0] align_level(input logic [7:0] lvl,
                                                        input int ch_w);
        logic [MAX_CH_W-1:0] full;
        full = {lvl, {(MAX_CH_W-8){1'b0}}};
        return full >> (MAX_CH_W - ch_w);
    endfunction

    // Result is right-aligned: {R,G,B} occupies the low 3*ch_w bits.
    function automatic logic [3*MAX_CH_W-1:0] default_entry(input logic [7:0] idx8,
                                                             input int ch_w);
        logic [3*MAX_CH_W-1:0] r;
        logic [3*MAX_CH_W-1:0] g;
        logic [3*MAX_CH_W-1:0] b;
        r = {{(2*MAX_CH_W){1'b0}}, align_level(level8(idx8[7:5]), ch_w)};
        g = {{(2*MAX_CH_W){1'b0}}, align_level(level8(idx8[4:2]), ch_w)};
        b = {{(2*MAX_CH_W){1'b0}}, align_level(level4(idx8[1:0]), ch_w)};
        return (r << (2*ch_w)) | (g << ch_w) | b;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// -----------------------------------------------------------------------------
// palette_ram
// Simple dual-port palette storage: one synchronous write port and one
// registered read port. A read and write to the same address in the same cycle
// returns the old contents (read-first).
//   clk    in   clock
//   we     in   write enable
//   wa     in   write address
//   wd     in   write data
//   re     in   read enable
//   ra     in   read address
//   rdata  out  registered read data (valid the cycle after re)
// -----------------------------------------------------------------------------
module palette_ram #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both accesses in one block: the read samples mem before the write's
    // non-blocking update lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rdata <= mem[ra];
        end
    end

endmodule

// File: rtl/palette_lut.sv
// -----------------------------------------------------------------------------
// palette_lut
// Multi-bank colour palette lookup. After reset every entry of every bank is
// filled with a default colour table, one entry per cycle; then pixel indices
// are looked up with a fixed two-cycle latency in the active bank, while a
// writer may update any bank. The active bank only changes on a frame_start
// pulse so a frame is never displayed from two palettes.
//   clk           in   clock
//   reset         in   asynchronous active-high reset
//   frame_start   in   frame start pulse; bank_sel is sampled here
//   bank_sel      in   requested display bank
//   rd_valid_in   in   qualifies rd_idx
//   rd_idx        in   pixel palette index
//   rd_valid_out  out  qualifies rd_color (rd_valid_in delayed 2 cycles)
//   rd_color      out  looked-up colour {R,G,B}
//   wr_en         in   palette write strobe
//   wr_bank       in   bank written
//   wr_idx        in   entry written
//   wr_data       in   colour written
//   wr_ready      out  writes are accepted (not filling)
//   init_busy     out  default-table fill in progress
// -----------------------------------------------------------------------------
module palette_lut
    import palette_pkg::*;
#(
    parameter  int IDX_W     = 8,
    parameter  int CH_W      = 8,
    parameter  int NUM_BANKS = 4,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int COLOR_W   = 3*CH_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [BANK_W-1:0]  bank_sel,
    input  logic               rd_valid_in,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid_out,
    output logic [COLOR_W-1:0] rd_color,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_ready,
    output logic               init_busy
);

    localparam int ADDR_W = BANK_W + IDX_W;
    localparam int DEPTH  = NUM_BANKS * (2**IDX_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    lut_state_t        state_q;
    lut_state_t        state_d;
    logic [ADDR_W-1:0] fill_cnt_q;
    logic [ADDR_W-1:0] fill_cnt_d;
    logic [BANK_W-1:0] active_bank;

    logic               wr_bank_ok;
    logic               sel_bank_ok;
    logic [7:0]         fill_idx8;
    logic [COLOR_W-1:0] fill_data;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_wa;
    logic [COLOR_W-1:0] ram_wd;
    logic [COLOR_W-1:0] ram_q;

    logic vld_p0;
    logic init_p0;

    // Bank range checks only exist when NUM_BANKS leaves unused bank codes.
    if (NUM_BANKS == (1 << BANK_W)) begin : g_full_banks
        assign wr_bank_ok  = 1'b1;
        assign sel_bank_ok = 1'b1;
    end else begin : g_partial_banks
        assign wr_bank_ok  = (int'(wr_bank)  < NUM_BANKS);
        assign sel_bank_ok = (int'(bank_sel) < NUM_BANKS);
    end

    // The fill counter is bank-major, so its low IDX_W bits are the index.
    // Index bits above IDX_W read as zero for the default table.
    if (IDX_W >= 8) begin : g_idx_wide
        assign fill_idx8 = fill_cnt_q[7:0];
    end else begin : g_idx_narrow
        assign fill_idx8 = {{(8-IDX_W){1'b0}}, fill_cnt_q[IDX_W-1:0]};
    end

    assign fill_data = COLOR_W'(default_entry(fill_idx8, CH_W));

    // ---------------------------------------------------------------- fill FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            ST_INIT: begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    fill_cnt_d = '0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_INIT;
                fill_cnt_d = '0;
            end
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign wr_ready  = !init_busy;

    // Display bank switches only at frame boundaries; out-of-range requests
    // leave the current palette in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_bank <= '0;
        end else if (frame_start && sel_bank_ok) begin
            active_bank <= bank_sel;
        end
    end

    // The fill owns the write port while busy, so user writes then are dropped.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = fill_cnt_q;
        ram_wd = fill_data;
        if (init_busy) begin
            ram_we = 1'b1;
        end else if (wr_en && wr_bank_ok) begin
            ram_we = 1'b1;
            ram_wa = {wr_bank, wr_idx};
            ram_wd = wr_data;
        end
    end

    // ---------------------------------------------------------------- stage p0: RAM read
    palette_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (COLOR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wa    (ram_wa),
        .wd    (ram_wd),
        .re    (rd_valid_in),
        .ra    ({active_bank, rd_idx}),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            init_p0 <= 1'b0;
        end else begin
            vld_p0  <= rd_valid_in;
            init_p0 <= init_busy;
        end
    end

    // ---------------------------------------------------------------- stage p1: output register
    // Reads issued during the fill return black; the colour holds between
    // valid beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_out <= 1'b0;
            rd_color     <= '0;
        end else begin
            rd_valid_out <= vld_p0;
            if (vld_p0) begin
                rd_color <= init_p0 ? '0 : ram_q;
            end
        end
    end

endmodule
